// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared combinational adder: grants one requester
// per cycle and captures the adder result in a single-entry response register.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_sum,
  input  logic               add_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
  output logic [15:0]        ops_count,
  output logic               busy
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [15:0]    cnt_q, cnt_d;

  logic           hit;
  logic [IDW-1:0] win_id;
  logic           slot_free;
  logic           grant;

  // Scan from ptr upward; N_REQ is a power of two so the IDW-bit sum wraps for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit    = 1'b0;
    win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hit && req_valid[ptr_q + IDW'(k)]) begin
        hit    = 1'b1;
        win_id = ptr_q + IDW'(k);
      end
    end
  end

  // A full slot can be refilled in the same cycle it drains.
  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  assign grant     = hit && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
      add_a             = req_a[win_id*W +: W];
      add_b             = req_b[win_id*W +: W];
      add_cin           = req_cin[win_id];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = ST_FULL;
      ptr_d   = win_id + IDW'(1);
      id_d    = win_id;
      sum_d   = add_sum;
      cout_d  = add_cout;
      cnt_d   = cnt_q + 16'd1;
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign ops_count = cnt_q;
  assign busy      = rsp_valid || (|req_valid);

endmodule
